fifo_sync_param: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Adds:
  - configurable width, depth and almost-full/almost-empty thresholds;
  - standard or first-word-fall-through (FWFT) read mode;
  - live occupancy count;
  - registered write-ack, overflow and underflow pulses.
- Sits between producer and consumer blocks in the same clock domain; the existing transaction-based bench drives it through the FIFO interface.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_mem_dp.sv | 19 +
 rtl/fifo_sync_param.sv | 115 +++++++++++
 tb/tb_fifo_sync_param.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and depth helper shared by the parametrised FIFO
package fifo_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2_depth(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: DATA_WIDTH x DEPTH storage, one synchronous write port, one async read port
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO, standard or FWFT read, with status pulses.
// Define FIFO_WATERMARK_EN to add the max_count high-water mark output.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AFULL_THR  = 7,
  parameter int AEMPTY_THR = 1,
  parameter int FWFT       = FIFO_MODE_STD,
  localparam int CNT_W     = clog2_depth(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_WATERMARK_EN
  ,
  output logic [CNT_W-1:0]      max_count
`endif
);
  localparam int PW = clog2_depth(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AFULL_THR);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AEMPTY_THR);
  localparam logic [PW-1:0]    LAST    = PW'(DEPTH - 1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d, rd_data;
  logic                  wr_ack_q, wr_ack_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
`ifdef FIFO_WATERMARK_EN
  logic [CNT_W-1:0]      max_count_q, max_count_d;
`endif

  assign full         = count_q == DEPTH_C;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF_C;
  assign almost_empty = count_q <= AE_C;
  assign count        = count_q;
  assign wr_ack       = wr_ack_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_out     = (FWFT == FIFO_MODE_FWFT) ? rd_data : data_out_q;

  // A write at full is rejected even with a concurrent read; a read at empty is always rejected.
  always_comb begin
    wr_acc      = wr_en && !full;
    rd_acc      = rd_en && !empty;
    wr_ptr_d    = wr_acc ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    data_out_d  = rd_acc ? rd_data : data_out_q;
    wr_ack_d    = wr_acc;
    overflow_d  = wr_en && full;
    underflow_d = rd_en && empty;
`ifdef FIFO_WATERMARK_EN
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef FIFO_WATERMARK_EN
      max_count_q <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef FIFO_WATERMARK_EN
      max_count_q <= max_count_d;
`endif
    end
  end

`ifdef FIFO_WATERMARK_EN
  assign max_count = max_count_q;
`endif

  fifo_mem_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (PW)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: queue-model scoreboard driving a standard-mode and an FWFT-mode FIFO in lockstep
module tb_fifo_sync_param;
  localparam int DW = 16, DEPTH = 8, AFT = 7, AET = 1, CW = 4;

  typedef struct {
    int          cnt;
    bit          ack, ovf, unf, hv;
    logic [15:0] dstd, head;
    int          maxc;
  } exp_t;

  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0;
  logic [DW-1:0] data_in = '0, dout_s, dout_f;
  logic [CW-1:0] cnt_s, cnt_f;
  logic full_s, empty_s, af_s, ae_s, ack_s, ovf_s, unf_s;
  logic full_f, empty_f, af_f, ae_f, ack_f, ovf_f, unf_f;
`ifdef FIFO_WATERMARK_EN
  logic [CW-1:0] max_s, max_f;
`endif

  exp_t        sb[$];
  logic [15:0] mq[$];
  logic [15:0] dstd_m = '0;
  int          maxc_m = 0, n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THR(AFT), .AEMPTY_THR(AET), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .data_out(dout_s),
    .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s), .count(cnt_s),
    .wr_ack(ack_s), .overflow(ovf_s), .underflow(unf_s)
`ifdef FIFO_WATERMARK_EN
    , .max_count(max_s)
`endif
  );

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THR(AFT), .AEMPTY_THR(AET), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .data_out(dout_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f), .count(cnt_f),
    .wr_ack(ack_f), .overflow(ovf_f), .underflow(unf_f)
`ifdef FIFO_WATERMARK_EN
    , .max_count(max_f)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and push what the FIFO must show after the coming edge.
  task automatic step(input bit rs, input bit w, input bit rd, input logic [15:0] d);
    exp_t e;
    bit f, em, wa, ra;
    @(negedge clk);
    rst = rs; wr_en = w; rd_en = rd; data_in = d;
    if (rs) begin
      mq.delete();
      dstd_m = '0;
      maxc_m = 0;
      e.ack = 0; e.ovf = 0; e.unf = 0;
    end else begin
      f  = mq.size() == DEPTH;
      em = mq.size() == 0;
      wa = w && !f;
      ra = rd && !em;
      if (ra) dstd_m = mq.pop_front();
      if (wa) mq.push_back(d);
      e.ack = wa; e.ovf = w && f; e.unf = rd && em;
      if (mq.size() > maxc_m) maxc_m = mq.size();
    end
    e.cnt  = mq.size();
    e.dstd = dstd_m;
    e.hv   = mq.size() != 0;
    e.head = e.hv ? mq[0] : '0;
    e.maxc = maxc_m;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        m = sb.pop_front();
        chk("count", 32'(cnt_s), m.cnt);
        chk("full", 32'(full_s), 32'(m.cnt == DEPTH));
        chk("empty", 32'(empty_s), 32'(m.cnt == 0));
        chk("almost_full", 32'(af_s), 32'(m.cnt >= AFT));
        chk("almost_empty", 32'(ae_s), 32'(m.cnt <= AET));
        chk("wr_ack", 32'(ack_s), 32'(m.ack));
        chk("overflow", 32'(ovf_s), 32'(m.ovf));
        chk("underflow", 32'(unf_s), 32'(m.unf));
        chk("data_out_std", 32'(dout_s), 32'(m.dstd));
        chk("count_fwft", 32'(cnt_f), m.cnt);
        chk("flags_fwft", 32'({full_f, empty_f, af_f, ae_f}),
            32'({m.cnt == DEPTH, m.cnt == 0, m.cnt >= AFT, m.cnt <= AET}));
        chk("pulses_fwft", 32'({ack_f, ovf_f, unf_f}), 32'({m.ack, m.ovf, m.unf}));
        if (m.hv) chk("data_out_fwft", 32'(dout_f), 32'(m.head));
`ifdef FIFO_WATERMARK_EN
        chk("max_count", 32'(max_s), m.maxc);
        chk("max_count_fwft", 32'(max_f), m.maxc);
`endif
      end
    end
  end

  initial begin
    step(1, 1, 1, 16'h1234);
    step(1, 0, 0, 16'h0000);
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 16'(i));
    step(0, 1, 0, 16'hDEAD);
    step(0, 1, 1, 16'hBEEF);
    repeat (8) step(0, 0, 1, 16'h0000);
    step(0, 1, 1, 16'h0055);
    repeat (3) step(0, 1, 0, 16'($urandom));
    step(0, 1, 1, 16'h0066);
    repeat (5) step(0, 0, 1, 16'h0000);
    for (int i = 0; i < 120; i++) begin
      if (i % 3 == 2 || mq.size() == DEPTH) step(0, 0, 1, 16'h0000);
      else step(0, 1, 0, 16'($urandom));
    end
    for (int i = 0; i < 400; i++)
      step(($urandom % 64) == 0, 1'($urandom), 1'($urandom), 16'($urandom));
    repeat (9) step(0, 0, 1, 16'h0000);
    step(0, 1, 0, 16'h00AA);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h0000);
    step(0, 0, 0, 16'h0000);
    step(1, 0, 0, 16'h0000);
    repeat (5) step(0, 1, 0, 16'($urandom));
    step(0, 0, 0, 16'h0000);
    step(1, 1, 1, 16'h7777);
    step(0, 0, 0, 16'h0000);
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
